// File: rtl/seg7_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } slot_e;

    function automatic int idx_width(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

    function automatic int pre_width(input int refresh_div);
        return (refresh_div > 1) ? $clog2(refresh_div) : 1;
    endfunction

endpackage

// File: rtl/hex_decoder.sv
// Hex nibble to seven-segment pattern {g..a}; INVERT flips to active-low.
module hex_decoder #(
    parameter bit INVERT = 1'b0
) (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    logic [6:0] raw;

    always_comb begin
        raw = 7'h00;
        case (nibble)
            4'h0: raw = 7'h3F;
            4'h1: raw = 7'h06;
            4'h2: raw = 7'h5B;
            4'h3: raw = 7'h4F;
            4'h4: raw = 7'h66;
            4'h5: raw = 7'h6D;
            4'h6: raw = 7'h7D;
            4'h7: raw = 7'h07;
            4'h8: raw = 7'h7F;
            4'h9: raw = 7'h6F;
            4'hA: raw = 7'h77;
            4'hB: raw = 7'h7C;
            4'hC: raw = 7'h39;
            4'hD: raw = 7'h5E;
            4'hE: raw = 7'h79;
            default: raw = 7'h71;
        endcase
        seg = INVERT ? ~raw : raw;
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scanner with frame-synchronous double buffer.
// Optional leading-zero blanking is enabled by defining SEG7_ZERO_BLANK_EN.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGITS         = 8,
    parameter int REFRESH_DIV    = 100000,
    parameter int BLANK_CYCLES   = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [4*DIGITS-1:0]   wr_data,
    input  logic [DIGITS-1:0]     wr_dp,
    input  logic [DIGITS-1:0]     digit_mask,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int IDX_W = idx_width(DIGITS);
    localparam int PRE_W = pre_width(REFRESH_DIV);
    localparam logic [6:0]        SEG_INACT = SEG_ACTIVE_LOW ? SEG_OFF : ~SEG_OFF;
    localparam logic [DIGITS-1:0] AN_INACT  = AN_ACTIVE_LOW ? '1 : '0;

    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] shadow_data_q, shadow_data_d;
    logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [4*DIGITS-1:0] disp_data_q, disp_data_d;
    logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                frame_done_q, frame_done_d;
    logic [IDX_W-1:0]    msd_q, msd_d;

    logic        term_cnt, boundary, digit_on;
    slot_e       slot;
    logic [3:0]  nibble;
    logic [6:0]  seg_raw;
    logic [DIGITS-1:0] an_act;

    always_comb begin
        term_cnt = (pre_q == PRE_W'(REFRESH_DIV - 1));
        boundary = term_cnt && (idx_q == IDX_W'(DIGITS - 1));
        pre_d    = term_cnt ? '0 : pre_q + 1'b1;
        idx_d    = idx_q;
        if (term_cnt) begin
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        slot = (pre_q < PRE_W'(BLANK_CYCLES)) ? BLANK : SHOW;
    end

    // A write landing on the boundary bypasses the shadow so it is not lost a frame.
    always_comb begin
        shadow_data_d = wr_en ? wr_data : shadow_data_q;
        shadow_dp_d   = wr_en ? wr_dp   : shadow_dp_q;
        disp_data_d   = disp_data_q;
        disp_dp_d     = disp_dp_q;
        frame_done_d  = boundary;
        if (boundary) begin
            disp_data_d = shadow_data_d;
            disp_dp_d   = shadow_dp_d;
        end
    end

`ifdef SEG7_ZERO_BLANK_EN
    always_comb begin
        msd_d = msd_q;
        if (boundary) begin
            msd_d = '0;
            for (int i = 0; i < DIGITS; i++) begin
                if (disp_data_d[4*i +: 4] != 4'h0) msd_d = IDX_W'(i);
            end
        end
    end
    assign digit_on = digit_mask[idx_q] && (idx_q <= msd_q);
`else
    assign msd_d    = '0;
    assign digit_on = digit_mask[idx_q];
`endif

    assign nibble = disp_data_q[{idx_q, 2'b00} +: 4];

    hex_decoder #(.INVERT(1'b0)) u_hex_decoder (
        .nibble (nibble),
        .seg    (seg_raw)
    );

    always_comb begin
        an_act = '0;
        seg_d  = SEG_INACT;
        dp_d   = SEG_ACTIVE_LOW;
        if (slot == SHOW && digit_on) begin
            an_act[idx_q] = 1'b1;
            seg_d = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
            dp_d  = disp_dp_q[idx_q] ^ SEG_ACTIVE_LOW;
        end
        an_d = AN_ACTIVE_LOW ? ~an_act : an_act;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q         <= '0;
            idx_q         <= '0;
            shadow_data_q <= '0;
            shadow_dp_q   <= '0;
            disp_data_q   <= '0;
            disp_dp_q     <= '0;
            msd_q         <= '0;
            seg_q         <= SEG_INACT;
            dp_q          <= SEG_ACTIVE_LOW;
            an_q          <= AN_INACT;
            frame_done_q  <= 1'b0;
        end else begin
            pre_q         <= pre_d;
            idx_q         <= idx_d;
            shadow_data_q <= shadow_data_d;
            shadow_dp_q   <= shadow_dp_d;
            disp_data_q   <= disp_data_d;
            disp_dp_q     <= disp_dp_d;
            msd_q         <= msd_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            an_q          <= an_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, active-low pins.
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [15:0] wr_data = '0;
    logic [3:0]  wr_dp = '0;
    logic [3:0]  digit_mask = 4'hF;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int onehot_err = 0;

    seg7_scan_ctrl #(
        .DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2),
        .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_dp(wr_dp),
        .digit_mask(digit_mask), .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && $countones(~an) > 1) onehot_err++;
    end

    typedef struct {
        int          cyc;
        bit          wr;
        logic [15:0] wd;
        logic [3:0]  wdp;
        logic [3:0]  mask;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
        logic        fd;
    } vec_t;

    vec_t vecs[27];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic step_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                              input logic e_dp, input logic e_fd);
        check({tag, ".an"}, {12'h0, an}, {12'h0, e_an});
        check({tag, ".seg"}, {9'h0, seg}, {9'h0, e_seg});
        check({tag, ".dp"}, {15'h0, dp}, {15'h0, e_dp});
        check({tag, ".fd"}, {15'h0, frame_done}, {15'h0, e_fd});
    endtask

    function automatic vec_t mk(input int c, input bit w, input logic [15:0] wd, input logic [3:0] wdp,
                                input logic [3:0] m, input logic [3:0] a, input logic [6:0] s,
                                input logic d, input logic f);
        vec_t v;
        v.cyc = c; v.wr = w; v.wd = wd; v.wdp = wdp; v.mask = m;
        v.an = a; v.seg = s; v.dp = d; v.fd = f;
        return v;
    endfunction

    initial begin
        int viol;
        vecs[0]  = mk(1,   0, 16'h0,    4'h0, 4'hF, 4'hF, 7'h7F, 1, 0);
        vecs[1]  = mk(3,   0, 16'h0,    4'h0, 4'hF, 4'hE, 7'h40, 1, 0);
        vecs[2]  = mk(5,   1, 16'h12AF, 4'h0, 4'hF, 4'hE, 7'h40, 1, 0);
        vecs[3]  = mk(8,   0, 16'h0,    4'h0, 4'hF, 4'hE, 7'h40, 1, 0);
        vecs[4]  = mk(9,   0, 16'h0,    4'h0, 4'hF, 4'hF, 7'h7F, 1, 0);
        vecs[5]  = mk(11,  0, 16'h0,    4'h0, 4'hF, 4'hD, 7'h40, 1, 0);
        vecs[6]  = mk(27,  0, 16'h0,    4'h0, 4'hF, 4'h7, 7'h40, 1, 0);
        vecs[7]  = mk(31,  0, 16'h0,    4'h0, 4'hF, 4'h7, 7'h40, 1, 0);
        vecs[8]  = mk(32,  0, 16'h0,    4'h0, 4'hF, 4'h7, 7'h40, 1, 1);
        vecs[9]  = mk(33,  0, 16'h0,    4'h0, 4'hF, 4'hF, 7'h7F, 1, 0);
        vecs[10] = mk(35,  0, 16'h0,    4'h0, 4'hF, 4'hE, 7'h0E, 1, 0);
        vecs[11] = mk(43,  0, 16'h0,    4'h0, 4'hF, 4'hD, 7'h08, 1, 0);
        vecs[12] = mk(51,  0, 16'h0,    4'h0, 4'hF, 4'hB, 7'h24, 1, 0);
        vecs[13] = mk(59,  0, 16'h0,    4'h0, 4'hF, 4'h7, 7'h79, 1, 0);
        vecs[14] = mk(64,  0, 16'h0,    4'h0, 4'hF, 4'h7, 7'h79, 1, 1);
        vecs[15] = mk(96,  1, 16'h0003, 4'h0, 4'hF, 4'h7, 7'h79, 1, 1);
        vecs[16] = mk(97,  1, 16'h0004, 4'h0, 4'hF, 4'hF, 7'h7F, 1, 0);
        vecs[17] = mk(99,  0, 16'h0,    4'h0, 4'hF, 4'hE, 7'h30, 1, 0);
        vecs[18] = mk(107, 0, 16'h0,    4'h0, 4'hF, 4'hD, 7'h40, 1, 0);
        vecs[19] = mk(128, 0, 16'h0,    4'h0, 4'hF, 4'h7, 7'h40, 1, 1);
        vecs[20] = mk(131, 0, 16'h0,    4'h0, 4'hF, 4'hE, 7'h19, 1, 0);
        vecs[21] = mk(140, 1, 16'h4321, 4'h1, 4'h5, 4'hF, 7'h7F, 1, 0);
        vecs[22] = mk(163, 0, 16'h0,    4'h0, 4'h5, 4'hE, 7'h79, 0, 0);
        vecs[23] = mk(171, 0, 16'h0,    4'h0, 4'h5, 4'hF, 7'h7F, 1, 0);
        vecs[24] = mk(179, 0, 16'h0,    4'h0, 4'h5, 4'hB, 7'h30, 1, 0);
        vecs[25] = mk(187, 0, 16'h0,    4'h0, 4'h5, 4'hF, 7'h7F, 1, 0);
        vecs[26] = mk(192, 0, 16'h0,    4'h0, 4'h5, 4'hF, 7'h7F, 1, 1);

        repeat (2) @(negedge clk);
        check_outs("reset", 4'hF, 7'h7F, 1'b1, 1'b0);
        rst = 1'b0;
        cyc = 0;

        foreach (vecs[i]) begin
            step_to(vecs[i].cyc - 1);
            digit_mask = vecs[i].mask;
            if (vecs[i].wr) begin
                wr_en = 1'b1; wr_data = vecs[i].wd; wr_dp = vecs[i].wdp;
            end
            step_to(vecs[i].cyc);
            wr_en = 1'b0;
            check_outs($sformatf("vec%0d", i), vecs[i].an, vecs[i].seg, vecs[i].dp, vecs[i].fd);
        end

        // Masked digits 1 and 3 never light; dp lit only while digit 0 is selected.
        viol = 0;
        repeat (32) begin
            step_to(cyc + 1);
            if (an[1] !== 1'b1 || an[3] !== 1'b1) viol++;
            if ((dp === 1'b0) !== (an === 4'hE)) viol++;
        end
        check("mask_frame_viol", 16'(viol), 16'd0);

        // Reset mid-SHOW of idx 2 clears outputs without waiting for a clock edge.
        step_to(245);
        check_outs("pre_rst", 4'hB, 7'h30, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1 check_outs("async_rst", 4'hF, 7'h7F, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        digit_mask = 4'hF;
        cyc = 0;
        step_to(2);
        check_outs("restart_blank", 4'hF, 7'h7F, 1'b1, 1'b0);
        step_to(3);
        check_outs("restart_idx0", 4'hE, 7'h40, 1'b1, 1'b0);
        step_to(32);
        check_outs("restart_fd", 4'h7, 7'h40, 1'b1, 1'b1);
        step_to(35);
        check_outs("shadow_cleared", 4'hE, 7'h40, 1'b1, 1'b0);

        step_to(39);
        wr_en = 1'b1; wr_data = 16'h0050; wr_dp = 4'h0;
        step_to(40);
        wr_en = 1'b0;
        step_to(67);
        check_outs("zb50_d0", 4'hE, 7'h40, 1'b1, 1'b0);
        step_to(75);
        check_outs("zb50_d1", 4'hD, 7'h12, 1'b1, 1'b0);
        step_to(83);
`ifdef SEG7_ZERO_BLANK_EN
        check_outs("zb50_d2", 4'hF, 7'h7F, 1'b1, 1'b0);
`else
        check_outs("zb50_d2", 4'hB, 7'h40, 1'b1, 1'b0);
`endif
        step_to(89);
        wr_en = 1'b1; wr_data = 16'h0000;
        step_to(90);
        wr_en = 1'b0;
        step_to(99);
        check_outs("zb00_d0", 4'hE, 7'h40, 1'b1, 1'b0);
        step_to(107);
`ifdef SEG7_ZERO_BLANK_EN
        check_outs("zb00_d1", 4'hF, 7'h7F, 1'b1, 1'b0);
`else
        check_outs("zb00_d1", 4'hD, 7'h40, 1'b1, 1'b0);
`endif

        check("onehot_an", 16'(onehot_err), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexing controller for a common-anode multi-digit seven-segment display on the board I/O. It holds a DIGITS-nibble display value, scans one digit at a time at a fixed refresh rate, and feeds the active nibble through one shared hex_decoder instance. It drives the segment, decimal-point and anode pins. A frame-synchronous double buffer ensures CPU writes never tear a displayed frame.

## Interface
- DIGITS, 8: number of digits scanned (2..8)
- REFRESH_DIV, 100000: clock cycles per digit slot (>= BLANK_CYCLES+2)
- BLANK_CYCLES, 16: anti-ghosting gap at the start of each slot with all anodes off (>= 1)
- SEG_ACTIVE_LOW, 1: 1 = segment/dp pins driven low to light
- AN_ACTIVE_LOW, 1: 1 = anode pins driven low to select
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- wr_en  input  1  load wr_data/wr_dp into the shadow register this cycle
- wr_data  input  4*DIGITS  nibble i drives digit i; digit 0 is rightmost
- wr_dp  input  DIGITS  decimal point per digit, 1 = lit
- digit_mask  input  DIGITS  1 = digit enabled; sampled live every cycle
- seg  output  7  segments {g..a}, polarity per SEG_ACTIVE_LOW
- dp  output  1  decimal point, polarity per SEG_ACTIVE_LOW
- an  output  DIGITS  anode selects, polarity per AN_ACTIVE_LOW
- frame_done  output  1  one-cycle pulse when the display register loads

## Operation
- Prescaler pre counts 0..REFRESH_DIV-1 and wraps. At terminal count, digit index idx advances 0->1->...->DIGITS-1->0.
- Frame boundary = terminal count while idx==DIGITS-1. On that cycle, disp_data/disp_dp load from shadow and frame_done pulses.
- Shadow loads on any wr_en cycle. Last write before a boundary wins.
- If wr_en coincides with a boundary, display loads wr_data/wr_dp directly (bypass) and shadow takes the same value.
- Slot states per idx: BLANK (pre < BLANK_CYCLES; all anodes inactive, seg/dp inactive) -> SHOW (pre >= BLANK_CYCLES).
- In SHOW, an[idx] is active only if digit_mask[idx]=1. seg = decode(disp_data nibble idx) and dp = disp_dp[idx].
- A masked digit produces all anodes inactive and seg/dp inactive for the whole slot. It is still scanned, so refresh rate is constant.
- The decoder runs non-inverted; this block applies SEG_ACTIVE_LOW polarity once at the output register.

## Timing
- Reset values: pre=0, idx=0, shadow=0, disp=0, frame_done=0. an/seg/dp at inactive levels (all 1s when active-low).
- seg, dp, an and frame_done are registered and lag counter state by one cycle. an[idx] first asserts on the cycle after pre==BLANK_CYCLES.
- Write-to-display latency is at most DIGITS*REFRESH_DIV+1 cycles. frame_done is high the same cycle the new value is first decoded (registered view).
- Frame period is exactly DIGITS*REFRESH_DIV cycles. There is no idle state.
- Reset asserted mid-scan forces all outputs inactive asynchronously. Scanning restarts at idx=0 after deassertion, and any pending shadow contents are discarded.
- At most one anode is ever active; an is never active during BLANK.

## Configuration
- SEG7_ZERO_BLANK_EN defined: at each frame load, compute msd = highest index with a nonzero nibble (0 if the value is all zero). Digits with idx > msd are treated as masked for that frame. The msd is registered with disp.
- Undefined: only digit_mask gates digits; zeros are displayed as "0".

## Structure
- seg7_pkg holds: SEG_OFF (7'b1111111 active-low pattern), the idx/pre width functions ($clog2 of DIGITS and REFRESH_DIV), and the slot-state enum BLANK/SHOW.
- One sub-module: the existing hex_decoder with invert=0, instantiated once and shared across digits.
- Counters, buffer and output registers live in seg7_scan_ctrl. No further sub-modules.

## Test plan
Bench parameters: DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, both polarities active-low.
- Reset then idle, digit_mask=4'hF -> an=4'b1110 from cycle 3 to 8 after deassert; seg=7'b1000000; frame_done first pulses at cycle 32.
- wr_data=16'h12AF at cycle 5 -> display unchanged (all "0") until the frame_done at cycle 32. Next frame shows F, A, 2, 1 on an 1110, 1101, 1011, 0111 with seg 0001110, 0001000, 0100100, 1111001.
- wr_en with 16'h0003 exactly on the boundary cycle -> frame_done and the new value take effect that frame (bypass). A second write of 16'h0004 one cycle later appears only in the following frame.
- digit_mask=4'b0101 and wr_dp=4'b0001 -> an never asserts bits 1 or 3; dp=0 only while an=1110.
- Assert rst mid-SHOW of idx=2 -> an=4'hF, seg=7'h7F, dp=1 immediately. After release, the scan restarts at idx=0 with disp=0.
- With SEG7_ZERO_BLANK_EN, value 16'h0050 -> only an bits 0 and 1 activate. Value 16'h0000 -> only digit 0 shows "0".
